// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE / ACCESS / RESP)
//   HOST/INST/DATA : requester indices (host loader, inst fetch, data port)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

  localparam int unsigned HOST = 0;
  localparam int unsigned INST = 1;
  localparam int unsigned DATA = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the memory model.
//   req_*  : per-requester request channel, flattened, slice i = requester i
//   resp_* : per-requester response channel; resp_rdata is shared
//   mem_*  : single-port synchronous memory, one-cycle read latency
// Modports: slave = arbiter view, master = requesters + memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*STRB_W-1:0] req_wstrb;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        resp_valid;
  logic [NREQ-1:0]        resp_ready;
  logic [DATA_W-1:0]      resp_rdata;
  logic                   mem_en;
  logic [STRB_W-1:0]      mem_wstrb;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_wstrb, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_en, mem_wstrb, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_wstrb, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_en, mem_wstrb, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_picker.sv
// Combinational winner selection for the memory port arbiter.
// The host (index 0) always wins when valid. Among the remaining requesters:
//   MEM_ARB_RR_EN defined   : round-robin starting at ptr
//   MEM_ARB_RR_EN undefined : fixed priority, highest index wins (ptr ignored)
// Ports:
//   req_valid : pending requests, one bit per requester
//   ptr       : round-robin start index (1..NREQ-1)
//   any       : some requester is valid
//   grant     : one-hot winner (zero when any=0)
//   idx       : winner index
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

`ifdef MEM_ARB_RR_EN
  int unsigned cand;

  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    cand  = 0;
    if (req_valid[HOST]) begin
      any         = 1'b1;
      grant[HOST] = 1'b1;
      idx         = IDX_W'(HOST);
    end else begin
      // walk indices 1..NREQ-1 circularly, starting at ptr
      for (int unsigned k = 0; k < NREQ - 1; k++) begin
        cand = ((32'(ptr) - 1 + k) % (NREQ - 1)) + 1;
        if (!any && req_valid[IDX_W'(cand)]) begin
          any                 = 1'b1;
          grant[IDX_W'(cand)] = 1'b1;
          idx                 = IDX_W'(cand);
        end
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    // ascending scan, later hits overwrite: highest valid index wins
    for (int unsigned i = 1; i < NREQ; i++) begin
      if (req_valid[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
    if (req_valid[HOST]) begin
      any = 1'b1;
      idx = IDX_W'(HOST);
    end
    if (any) grant[idx] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between host, inst fetch and data port.
// One transaction at a time: accept in IDLE (memory strobed combinationally),
// capture read data in ACCESS, present response in RESP until taken.
// Writes complete with a response carrying rdata 0.
// Optional feature: define MEM_ARB_RR_EN for round-robin among non-host
// requesters; otherwise the highest index wins.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : request/response/memory bundle, arbiter (slave) view
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(NREQ);

  arb_state_e        state, state_nxt;
  logic [IDX_W-1:0]  gidx_q;
  logic [IDX_W-1:0]  ptr_q;
  logic              wr_q;
  logic [DATA_W-1:0] rdata_q;

  logic              pick_any;
  logic [NREQ-1:0]   pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [STRB_W-1:0] sel_wstrb;
  logic [DATA_W-1:0] sel_wdata;

  mem_arb_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_valid (bus.req_valid),
    .ptr       (ptr_q),
    .any       (pick_any),
    .grant     (pick_grant),
    .idx       (pick_idx)
  );

  assign sel_addr  = bus.req_addr[32'(pick_idx) * ADDR_W +: ADDR_W];
  assign sel_wstrb = bus.req_wstrb[32'(pick_idx) * STRB_W +: STRB_W];
  assign sel_wdata = bus.req_wdata[32'(pick_idx) * DATA_W +: DATA_W];

  // no grant while reset is asserted, so a request is never lost to reset
  assign accept = (state == IDLE) && pick_any && !rst;

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = '0;
    bus.mem_en     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wstrb  = '0;
    bus.mem_wdata  = '0;
    bus.resp_valid = '0;
    bus.resp_rdata = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          bus.req_ready = pick_grant;
          bus.mem_en    = 1'b1;
          bus.mem_addr  = sel_addr & ~ADDR_W'(3);
          bus.mem_wstrb = sel_wstrb;
          bus.mem_wdata = sel_wdata;
          state_nxt     = ACCESS;
        end
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        bus.resp_valid[gidx_q] = 1'b1;
        bus.resp_rdata         = rdata_q;
        if (bus.resp_ready[gidx_q]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gidx_q  <= '0;
      ptr_q   <= IDX_W'(INST);
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        gidx_q <= pick_idx;
        wr_q   <= |sel_wstrb;
        if (pick_idx != IDX_W'(HOST))
          ptr_q <= (pick_idx == IDX_W'(NREQ - 1)) ? IDX_W'(INST) : pick_idx + 1'b1;
      end
      if (state == ACCESS) rdata_q <= wr_q ? '0 : bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned WORDS  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // memory device: driven only by the DUT's mem_* outputs (plus backdoor preload)
  logic [DATA_W-1:0] dev_mem [WORDS];
  logic              bd_we = 1'b0;
  logic [7:0]        bd_idx;
  logic [DATA_W-1:0] bd_val;

  always @(posedge clk) begin
    if (bd_we) dev_mem[bd_idx] <= bd_val;
    else if (bus.mem_en) begin
      bus.mem_rdata <= dev_mem[bus.mem_addr[9:2]];
      for (int b = 0; b < int'(STRB_W); b++)
        if (bus.mem_wstrb[b]) dev_mem[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
    end
  end

  // requester stimulus
  logic [NREQ-1:0]   r_valid = '0;
  logic [ADDR_W-1:0] r_addr  [NREQ];
  logic [STRB_W-1:0] r_wstrb [NREQ];
  logic [DATA_W-1:0] r_wdata [NREQ];
  logic [NREQ-1:0]   r_resp_ready = '1;
  logic [NREQ-1:0]   seen_ready;

  // transaction-level reference model
  logic [DATA_W-1:0] ref_mem [WORDS];
  int                rr_next = 1;
  bit                txn_open = 0;
  int                txn_who;
  int                txn_age;
  logic [DATA_W-1:0] txn_rdata;

  // observations of the DUT
  int                obs_grants[$];
  int                obs_resp = 0;
  logic [NREQ-1:0]   last_resp_who;
  logic [DATA_W-1:0] last_resp_data;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // host first; then round-robin from rr_next, or highest index
  function automatic int pick(input logic [NREQ-1:0] v);
    if (v[0]) return 0;
`ifdef MEM_ARB_RR_EN
    for (int k = 0; k < int'(NREQ) - 1; k++) begin
      int c;
      c = 1 + (rr_next - 1 + k) % (int'(NREQ) - 1);
      if (v[c]) return c;
    end
`else
    for (int c = int'(NREQ) - 1; c >= 1; c--)
      if (v[c]) return c;
`endif
    return -1;
  endfunction

  task automatic apply();
    bus.req_valid  = r_valid;
    bus.resp_ready = r_resp_ready;
    for (int i = 0; i < int'(NREQ); i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W]  = r_addr[i];
      bus.req_wstrb[i*STRB_W +: STRB_W] = r_wstrb[i];
      bus.req_wdata[i*DATA_W +: DATA_W] = r_wdata[i];
    end
  endtask

  // called between edges: compare outputs, then advance the model over the next edge
  task automatic check_cycle();
    int w;
    int idx;
    seen_ready = bus.req_ready;
    for (int i = 0; i < int'(NREQ); i++)
      if (bus.req_ready[i]) obs_grants.push_back(i);
    if ((bus.resp_valid & r_resp_ready) != '0) begin
      obs_resp++;
      last_resp_who  = bus.resp_valid;
      last_resp_data = bus.resp_rdata;
    end
    if (rst) begin
      check_eq("rst_req_ready", 64'(bus.req_ready), '0);
      check_eq("rst_mem_en", 64'(bus.mem_en), '0);
      txn_open = 0;
      rr_next  = 1;
      return;
    end
    if (!txn_open) begin
      w = pick(r_valid);
      check_eq("req_ready", 64'(bus.req_ready), 64'(onehot(w)));
      check_eq("resp_valid_idle", 64'(bus.resp_valid), '0);
      if (w >= 0) begin
        check_eq("mem_en", 64'(bus.mem_en), 64'(1));
        check_eq("mem_addr", 64'(bus.mem_addr), 64'(r_addr[w] & ~32'h3));
        check_eq("mem_wstrb", 64'(bus.mem_wstrb), 64'(r_wstrb[w]));
        check_eq("mem_wdata", 64'(bus.mem_wdata), 64'(r_wdata[w]));
        idx = int'(r_addr[w][9:2]);
        if (r_wstrb[w] == '0) txn_rdata = ref_mem[idx];
        else begin
          txn_rdata = '0;
          for (int b = 0; b < int'(STRB_W); b++)
            if (r_wstrb[w][b]) ref_mem[idx][b*8 +: 8] = r_wdata[w][b*8 +: 8];
        end
        txn_open = 1;
        txn_who  = w;
        txn_age  = 1;
        if (w != 0) rr_next = (w == int'(NREQ) - 1) ? 1 : w + 1;
      end else begin
        check_eq("mem_en_idle", 64'(bus.mem_en), '0);
        check_eq("mem_addr_idle", 64'(bus.mem_addr), '0);
        check_eq("mem_wstrb_idle", 64'(bus.mem_wstrb), '0);
        check_eq("mem_wdata_idle", 64'(bus.mem_wdata), '0);
      end
    end else begin
      check_eq("req_ready_busy", 64'(bus.req_ready), '0);
      check_eq("mem_en_busy", 64'(bus.mem_en), '0);
      check_eq("mem_addr_busy", 64'(bus.mem_addr), '0);
      check_eq("mem_wstrb_busy", 64'(bus.mem_wstrb), '0);
      check_eq("mem_wdata_busy", 64'(bus.mem_wdata), '0);
      if (txn_age >= 2) begin
        check_eq("resp_valid", 64'(bus.resp_valid), 64'(onehot(txn_who)));
        check_eq("resp_rdata", 64'(bus.resp_rdata), 64'(txn_rdata));
        if (r_resp_ready[txn_who]) txn_open = 0;
      end else begin
        check_eq("resp_valid_access", 64'(bus.resp_valid), '0);
        txn_age++;
      end
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_req_ready"}, 64'(bus.req_ready), '0);
    check_eq({pfx, "_resp_valid"}, 64'(bus.resp_valid), '0);
    check_eq({pfx, "_resp_rdata"}, 64'(bus.resp_rdata), '0);
    check_eq({pfx, "_mem_en"}, 64'(bus.mem_en), '0);
    check_eq({pfx, "_mem_addr"}, 64'(bus.mem_addr), '0);
    check_eq({pfx, "_mem_wstrb"}, 64'(bus.mem_wstrb), '0);
    check_eq({pfx, "_mem_wdata"}, 64'(bus.mem_wdata), '0);
  endtask

  task automatic tick(input string zero_pfx = "");
    apply();
    @(negedge clk);
    if (zero_pfx != "") check_all_zero(zero_pfx);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bit got;
    got = 0;
    r_valid[i] = 1'b1;
    r_addr[i]  = a;
    r_wstrb[i] = s;
    r_wdata[i] = d;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      got = seen_ready[i];
    end
    r_valid[i] = 1'b0;
    check_eq("issue_accept", 64'(got), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rc0;
    int gs;
    int exp_order[6];
    logic [DATA_W-1:0] v;

    for (int i = 0; i < int'(NREQ); i++) begin
      r_addr[i]  = '0;
      r_wstrb[i] = '0;
      r_wdata[i] = '0;
    end
    apply();

    // preload memory (device via backdoor, reference directly) under reset
    for (int i = 0; i < int'(WORDS); i++) begin
      v = $urandom;
      if (i == 65) v = 32'hDEAD_BEEF;
      if (i == 128) v = 32'h00AA_BBCC;
      bd_we      = 1'b1;
      bd_idx     = 8'(i);
      bd_val     = v;
      ref_mem[i] = v;
      @(posedge clk);
      #1;
    end
    bd_we = 1'b0;

    // reset state
    tick("reset");
    rst = 1'b0;
    tick("after_reset");

    // single inst read, response exactly two cycles after accept
    r_resp_ready = '1;
    issue(1, 32'h0000_0104, 4'b0000, 32'h0);
    rc0 = obs_resp;
    tick();
    check_eq("inst_rd_no_early_resp", 64'(obs_resp), 64'(rc0));
    tick();
    check_eq("inst_rd_resp_count", 64'(obs_resp), 64'(rc0 + 1));
    check_eq("inst_rd_who", 64'(last_resp_who), 64'(3'b010));
    check_eq("inst_rd_data", 64'(last_resp_data), 64'(32'hDEAD_BEEF));

    // data byte write to unaligned address, response data 0
    issue(2, 32'h0000_0203, 4'b1000, 32'h1200_0000);
    tick();
    tick();
    check_eq("data_wr_who", 64'(last_resp_who), 64'(3'b100));
    check_eq("data_wr_data", 64'(last_resp_data), '0);

    // host read with zero strobe and nonzero wdata: read, sees merged byte
    issue(0, 32'h0000_0200, 4'b0000, 32'hFFFF_FFFF);
    tick();
    tick();
    check_eq("host_rd_who", 64'(last_resp_who), 64'(3'b001));
    check_eq("host_rd_data", 64'(last_resp_data), 64'(32'h12AA_BBCC));

    // all three valid together: grant order
    gs = obs_grants.size();
    r_valid = '1;
    r_addr[0] = 32'h10; r_wstrb[0] = '0;
    r_addr[1] = 32'h20; r_wstrb[1] = '0;
    r_addr[2] = 32'h30; r_wstrb[2] = '0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (seen_ready[0]) r_valid[0] = 1'b0;
      for (int i = 1; i < int'(NREQ); i++)
        if (seen_ready[i]) r_addr[i] = r_addr[i] + 32'h40;
    end
`ifdef MEM_ARB_RR_EN
    exp_order = '{0, 1, 2, 1, 2, 1};
`else
    exp_order = '{0, 2, 2, 2, 2, 2};
`endif
    check_eq("order_count", 64'(obs_grants.size() - gs), 64'(6));
    for (int k = 0; k < 6; k++)
      if (gs + k < obs_grants.size())
        check_eq($sformatf("order_%0d", k), 64'(obs_grants[gs + k]), 64'(exp_order[k]));
    r_valid = '0;
    repeat (3) tick();

    // response back-pressure with a waiting request
    r_resp_ready = '0;
    issue(1, 32'h0000_0104, 4'b0000, 32'h0);
    r_valid[2] = 1'b1; r_addr[2] = 32'h44; r_wstrb[2] = '0; r_wdata[2] = 32'h5;
    repeat (6) tick();
    check_eq("bp_no_grant_while_busy", 64'(seen_ready), '0);
    r_resp_ready = '1;
    tick();
    check_eq("bp_resp_taken", 64'(last_resp_data), 64'(32'hDEAD_BEEF));
    tick();
    check_eq("bp_grant_after_resp", 64'(seen_ready), 64'(3'b100));
    r_valid[2] = 1'b0;
    repeat (3) tick();

    // reset during ACCESS: nothing comes back
    issue(2, 32'h0000_0048, 4'b0000, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rc0 = obs_resp;
    tick("post_rst");
    repeat (3) tick();
    check_eq("aborted_no_resp", 64'(obs_resp), 64'(rc0));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < int'(NREQ); i++) begin
        if (r_valid[i] && seen_ready[i]) r_valid[i] = 1'b0;
        else if (!r_valid[i]) begin
          if ($urandom_range(0, (i == 0) ? 7 : 1) == 0) begin
            r_valid[i] = 1'b1;
            r_addr[i]  = 32'($urandom_range(0, 1023));
            r_wstrb[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            r_wdata[i] = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) r_valid[i] = 1'b0;
      end
      r_resp_ready = NREQ'($urandom) | NREQ'($urandom);
    end
    r_valid = '0;
    r_resp_ready = '1;
    repeat (6) tick();
    check_eq("drained", 64'(txn_open), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port data-memory model between the host (AXI-lite loader/monitor) and the multi-cycle CPU's instruction-fetch and data ports. Requesters use valid/ready request and response handshakes; the arbiter grants one at a time, drives the one-cycle-latency synchronous memory, and returns the read data to the granted requester. It sits between the CPU core and the memory model inside the CPU top-level wrapper.

## Interface
- `NREQ`, 3: number of requesters; index 0 = host, 1 = inst fetch, 2 = data.
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: data width; strobe width is DATA_W/8.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  request accepted this cycle; one-hot or zero.
- `req_addr`  in  NREQ*ADDR_W  byte addresses; slice i belongs to requester i.
- `req_wstrb`  in  NREQ*DATA_W/8  byte write strobes; all zero means read.
- `req_wdata`  in  NREQ*DATA_W  write data.
- `resp_valid`  out  NREQ  response pending; one-hot or zero.
- `resp_ready`  in  NREQ  requester takes the response.
- `resp_rdata`  out  DATA_W  read data for the requester whose resp_valid bit is set.
- `mem_en`  out  1  memory access strobe.
- `mem_wstrb`  out  DATA_W/8  memory byte write enables.
- `mem_addr`  out  ADDR_W  word-aligned address: {req_addr[ADDR_W-1:2], 2'b00}.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after mem_en.

## Operation
- FSM with three states:
  - IDLE: if any req_valid is set, pick a winner g, assert req_ready[g] and mem_en, drive mem_addr/mem_wstrb/mem_wdata from slice g. Latch g, go to ACCESS.
  - ACCESS: capture mem_rdata into the response register, or capture 0 for a write. Go to RESP.
  - RESP: hold resp_valid[g] and resp_rdata. Return to IDLE when resp_ready[g] is set.
- Winner selection:
  - Host (index 0) always has strict priority.
  - Among indices 1..NREQ-1, selection follows the Configuration section.
- Writes return a response with rdata 0, so every request completes with exactly one response.
- Requester rules:
  - req_* must stay stable while req_valid is set and req_ready is 0.
  - A requester may drop req_valid without penalty before it is accepted.
- Boundary conditions:
  - Simultaneous valids: exactly one req_ready bit rises.
  - req_valid arriving during ACCESS or RESP: waits; no ready is asserted outside IDLE.
  - Strobe 4'b0000 is a read even if wdata is nonzero.
  - Reset mid-transaction: next cycle the FSM is IDLE and all outputs are at reset values. Any in-flight response is discarded.

## Timing
- Reset values:
  - req_ready=0, resp_valid=0, resp_rdata=0.
  - mem_en=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
  - FSM=IDLE; round-robin pointer selects index 1.
- req_ready and the mem_* outputs are combinational from req_valid/req_* in IDLE only.
- resp_valid rises 2 cycles after the accept edge (accept at T, ACCESS at T+1, RESP at T+2).
- Minimum period is 3 cycles per transaction when resp_ready is tied high.
- The mem_* outputs are 0 whenever mem_en=0.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin among indices 1..NREQ-1.
  - The pointer advances to the index after the last non-host winner, wrapping NREQ-1 to 1.
  - Host grants do not move the pointer.
- Undefined: fixed priority, higher index wins (data over inst fetch).

## Structure
- Shared package `mem_arb_pkg`:
  - FSM state enum (IDLE/ACCESS/RESP).
  - Requester index constants HOST=0, INST=1, DATA=2.
- One sub-module `mem_arb_picker`: combinational winner selection from req_valid and pointer, producing a one-hot grant and an index. The RR pointer register stays in the parent.

## Test plan
- Single inst read, addr 0x0000_0104, memory word 0xDEAD_BEEF, resp_ready=1 -> req_ready[1] at T, mem_addr=0x104, resp_valid[1] and rdata 0xDEAD_BEEF at T+2.
- Data write, addr 0x0000_0203, wstrb 4'b1000, wdata 0x1200_0000 -> mem_addr=0x200, mem_wstrb=4'b1000, then resp_valid[2] with rdata 0.
- Host plus inst plus data valid together, MEM_ARB_RR_EN defined -> grant order host, then inst, data, inst, data alternating while both stay valid.
- Same stimulus without the macro -> host, then data on every grant while data stays valid; inst is starved.
- resp_ready held low for 5 cycles -> resp_valid and rdata stable; no req_ready asserted; IDLE entered the cycle after resp_ready rises.
- rst pulsed during ACCESS -> next cycle all outputs 0, FSM IDLE; no response is issued for the aborted request.
